// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the CPU load/store stage and a word-addressed main memory.
// Loads that miss trigger a 4-word line refill. Every store becomes one word write to memory.
// Because memory is always current, a line is never written back when it is evicted.
module dcache_wt #(
    parameter int INDEX_W = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_le_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [127:0]      mem_rline_i,
    input  logic              mem_wa_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - 2 - INDEX_W;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_REFILL_REQ  = 2'd1;
    localparam logic [1:0] ST_REFILL_WAIT = 2'd2;
    localparam logic [1:0] ST_WRITE       = 2'd3;

    // Pick one 32-bit word out of a 128-bit line.
    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
        logic [31:0] w;
        case (off)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Replace one 32-bit word of a line and leave the other three words unchanged.
    function automatic logic [127:0] word_merge(input logic [127:0] line, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [127:0] r;
        r = line;
        case (off)
            2'd0:    r[31:0]   = w;
            2'd1:    r[63:32]  = w;
            2'd2:    r[95:64]  = w;
            2'd3:    r[127:96] = w;
            default: r = line;
        endcase
        return r;
    endfunction

    // Cache storage. Only the valid bits are reset.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    logic [1:0]        state_q, state_d;
    logic              mem_le_q, mem_le_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Address fields of the live CPU request.
    logic [1:0]         cpu_off_s;
    logic [INDEX_W-1:0] cpu_index_s;
    logic [TAG_W-1:0]   cpu_tag_s;
    logic               cpu_hit_s;

    // Address fields of the pending refill. mem_raddr doubles as the latch for this address.
    logic [INDEX_W-1:0] rf_index_s;
    logic [TAG_W-1:0]   rf_tag_s;

    // Address fields of the pending store. mem_waddr doubles as the latch for this address.
    logic [1:0]         st_off_s;
    logic [INDEX_W-1:0] st_index_s;
    logic [TAG_W-1:0]   st_tag_s;
    logic               st_hit_s;

    logic cpu_stall_s;
    logic refill_done_s;
    logic store_hit_s;

    assign cpu_off_s   = cpu_addr_i[1:0];
    assign cpu_index_s = cpu_addr_i[INDEX_W+1:2];
    assign cpu_tag_s   = cpu_addr_i[ADDR_W-1:INDEX_W+2];
    assign cpu_hit_s   = valid_q[cpu_index_s] && (tag_q[cpu_index_s] == cpu_tag_s);

    assign rf_index_s  = mem_raddr_q[INDEX_W+1:2];
    assign rf_tag_s    = mem_raddr_q[ADDR_W-1:INDEX_W+2];

    assign st_off_s    = mem_waddr_q[1:0];
    assign st_index_s  = mem_waddr_q[INDEX_W+1:2];
    assign st_tag_s    = mem_waddr_q[ADDR_W-1:INDEX_W+2];
    assign st_hit_s    = valid_q[st_index_s] && (tag_q[st_index_s] == st_tag_s);

    // The load hit data is combinational, so a hit completes in the same cycle.
    assign cpu_rdata_o = word_sel(data_q[cpu_index_s], cpu_off_s);
    assign cpu_stall_o = cpu_stall_s;

    assign mem_le_o    = mem_le_q;
    assign mem_we_o    = mem_we_q;
    assign mem_raddr_o = mem_raddr_q;
    assign mem_waddr_o = mem_waddr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Next state, stall, and the values that the memory-side registers take next.
    always_comb begin
        state_d       = state_q;
        mem_raddr_d   = mem_raddr_q;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_stall_s   = 1'b0;
        refill_done_s = 1'b0;
        store_hit_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_we_i) begin
                    // A store wins over a load that is asserted in the same cycle.
                    cpu_stall_s = 1'b1;
                    mem_waddr_d = cpu_addr_i;
                    mem_wdata_d = cpu_wdata_i;
                    state_d     = ST_WRITE;
                end else if (cpu_re_i) begin
                    if (cpu_hit_s) begin
                        cpu_stall_s = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        cpu_stall_s = 1'b1;
                        mem_raddr_d = {cpu_addr_i[ADDR_W-1:2], 2'b00};
                        state_d     = ST_REFILL_REQ;
                    end
                end else begin
                    cpu_stall_s = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_REFILL_REQ: begin
                cpu_stall_s = 1'b1;
                state_d     = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                cpu_stall_s = 1'b1;
                if (!mem_wa_i) begin
                    refill_done_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_REFILL_WAIT;
                end
            end
            ST_WRITE: begin
                // The store completes in this cycle. A store that hits also updates the cached word.
                cpu_stall_s = 1'b0;
                store_hit_s = st_hit_s;
                state_d     = ST_IDLE;
            end
            default: begin
                cpu_stall_s = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        mem_le_d = (state_d == ST_REFILL_REQ) || (state_d == ST_REFILL_WAIT);
        mem_we_d = (state_d == ST_WRITE);
    end

    // State register and registered memory strobes/addresses. Reset aborts any pending operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_le_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_raddr_q <= {ADDR_W{1'b0}};
            mem_waddr_q <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_le_q    <= mem_le_d;
            mem_we_q    <= mem_we_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Valid bits: all are cleared on reset, and a bit is set when its line finishes a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {LINES{1'b0}};
        end else if (refill_done_s) begin
            valid_q[rf_index_s] <= 1'b1;
        end
    end

    // Tag and data arrays (not reset). Reset blocks writes so that an aborted refill installs nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill_done_s) begin
                data_q[rf_index_s] <= mem_rline_i;
                tag_q[rf_index_s]  <= rf_tag_s;
            end else if (store_hit_s) begin
                data_q[st_index_s] <= word_merge(data_q[st_index_s], st_off_s, mem_wdata_q);
            end
        end
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. Sits between the CPU load/store stage and the word-addressed main memory block.
- Drives the memory's le/we/read-address/write-address/write-data lines and consumes its 128-bit line output and wa ready flag.
- Issues 4-word line refills on read misses and single-word writes for every store.
- Presents a single stall signal back to the pipeline.

Parameters:
- INDEX_W, 4, index bits; LINES = 2**INDEX_W lines of 4 x 32-bit words.
- ADDR_W, 16, word-address width; tag width = ADDR_W - 2 - INDEX_W (10 by default).

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous active-high reset
- cpu_re  in  1  load request; held until cpu_stall is low
- cpu_we  in  1  store request; held until cpu_stall is low
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_re=1 and cpu_stall=0
- cpu_stall  out  1  request not completing this cycle
- mem_le  out  1  line read enable to memory
- mem_raddr  out  ADDR_W  line-aligned read address (low 2 bits zero)
- mem_rline  in  128  {word3, word2, word1, word0} starting at mem_raddr
- mem_wa  in  1  memory ready flag; low in the cycle after memory samples mem_le=1
- mem_we  out  1  word write enable to memory
- mem_waddr  out  ADDR_W  write word address
- mem_wdata  out  32  write data

Behaviour:
- Address split: offset=addr[1:0], index=addr[INDEX_W+1:2], tag=addr[ADDR_W-1:INDEX_W+2].
- Storage per line: valid bit, tag, 128-bit data. Data and tags are not reset; only valid bits are cleared.
- Reset (rst=1 at posedge):
  - all valid bits cleared; state=IDLE
  - mem_le=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_wdata=0
  - cpu_stall=0 whenever no request is present
- Reset during REFILL_REQ/REFILL_WAIT/WRITE aborts the operation: no line installed, no memory write issued, mem_le/mem_we low next cycle.
- States: IDLE, REFILL_REQ, REFILL_WAIT, WRITE.
- IDLE, priority order:
  - cpu_we=1: latch addr/wdata; go WRITE; cpu_stall=1. cpu_re is ignored when both are asserted.
  - cpu_re=1 and hit (valid and tag match): cpu_rdata = selected word combinationally; cpu_stall=0; stay IDLE.
  - cpu_re=1 and miss: cpu_stall=1; latch line address; go REFILL_REQ.
- REFILL_REQ: mem_le=1, mem_raddr=line address; cpu_stall=1; go REFILL_WAIT.
- REFILL_WAIT:
  - mem_le stays 1 and cpu_stall=1.
  - When mem_wa=0 is sampled: write mem_rline into the line, set tag and valid=1, go IDLE.
  - While mem_wa=1: stay in REFILL_WAIT indefinitely.
- Load-miss timing: IDLE (miss) -> REQ -> WAIT -> IDLE (hit, stall low). That is 3 stall cycles minimum; data is delivered in the 4th cycle.
- WRITE:
  - mem_we=1 for exactly this one cycle, with mem_waddr/mem_wdata from the latch; cpu_stall=0 (store completes).
  - If the latched address hits, the same posedge updates that word in the line.
  - A miss does not allocate.
  - Next state IDLE.
- Store cost: one stall cycle plus the completion cycle. Back-to-back stores alternate IDLE/WRITE.
- Store to an address whose line is mid-refill cannot occur (the CPU is stalled).
- mem_le and mem_we are never asserted in the same cycle.
- Index wrap-around: addresses differing only in tag evict each other; the new fill overwrites the old line with no writeback, since memory is always current.
- mem_raddr must not exceed 16'hFFFC (line-aligned), so the memory's +3 word never wraps.

Test Plan:
- Reset, then cpu_re at addr 16'h0010 (memory words 0x10..0x13 = 0xA0..0xA3) -> mem_le high 2 cycles, mem_raddr=0x0010, cpu_stall high 3 cycles, then cpu_rdata=0xA0; next load of 0x0013 -> hit, stall 0, rdata 0xA3.
- Store 0xDEAD to 0x0011 after that line is cached -> one stall cycle, then mem_we=1, mem_waddr=0x0011, mem_wdata=0xDEAD; following load of 0x0011 hits and returns 0xDEAD with no mem_le.
- Store 0xBEEF to uncached 0x0200 -> mem_we pulse with correct address/data; subsequent load of 0x0200 misses, refills, and returns 0xBEEF from memory.
- Conflict: load 0x0010, then load 0x0410 (same index 4, different tag), then load 0x0010 -> three refills, correct data each time.
- Assert rst during REFILL_WAIT with mem_wa held at 1 -> mem_le low next cycle, state IDLE; repeating the same load misses again (line not valid).
- cpu_re and cpu_we both high at 0x0020 -> write performed, read ignored; mem_le never asserted.
